// File: rtl/csa_pkg.sv
// Shared definitions for the CSA record readers.
// Holds the reader FSM state encoding, the word-0 field layout helpers
// and the default record lengths of the CSA input and output streams.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } csa_state_e;

  localparam int unsigned CSA_DATA_WIDTH       = 32;
  localparam int unsigned CSA_IN_RECORD_WORDS  = 5;
  localparam int unsigned CSA_OUT_RECORD_WORDS = 7;

  // Word 0 carries {channel, seq}: channel in the top bits, seq from bit 0.
  localparam int unsigned CSA_WORD0_IDX = 0;
  localparam int unsigned CSA_SEQ_LSB   = 0;

  // Channel field width; a single channel still gets a 1-bit field.
  function automatic int unsigned csa_chan_bits(input int unsigned chan_num);
    return (chan_num > 1) ? $clog2(chan_num) : 1;
  endfunction

  // Sequence field width: everything in word 0 below the channel field.
  function automatic int unsigned csa_seq_bits(input int unsigned data_width,
                                               input int unsigned chan_bits);
    return data_width - chan_bits;
  endfunction

endpackage

// File: rtl/csa_seq_tracker.sv
// Per-channel sequence tracker.
// Ports:
//   axi_mm_clk, rst : clock, synchronous active-high reset
//   check           : strobe, compare and update the addressed channel
//   channel, seq    : fields taken from word 0 of the completed record
//   mismatch_c      : combinational, high when check finds seq != expected
module csa_seq_tracker
  import csa_pkg::*;
#(
  parameter int unsigned CHANNEL_BITS = 2,
  parameter int unsigned SEQ_BITS     = 30
) (
  input  logic                    axi_mm_clk,
  input  logic                    rst,
  input  logic                    check,
  input  logic [CHANNEL_BITS-1:0] channel,
  input  logic [SEQ_BITS-1:0]     seq,
  output logic                    mismatch_c
);

  // Sized to the full field range so every channel code has a slot.
  localparam int unsigned SLOTS = 1 << CHANNEL_BITS;

  logic [SEQ_BITS-1:0] expected_seq [SLOTS];

  assign mismatch_c = check && (seq != expected_seq[channel]);

  // Always resync to seq+1, so a gap is reported once and then tracked.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        expected_seq[i] <= SEQ_BITS'(1);
      end
    end else if (check) begin
      expected_seq[channel] <= seq + SEQ_BITS'(1);
    end
  end

endmodule

// File: rtl/csa_bulk_unpacker.sv
// Bulk record unpacker.
// Pops one RECORD_WORDS-word record from the bulk FIFO, assembles it into
// rec_data, presents it on a valid/ready interface and checks the
// per-channel sequence number carried in word 0.
// Ports:
//   axi_mm_clk, rst                : clock, synchronous active-high reset
//   fifo_r_ready, fifo_error_empty : FIFO has a full record / underflow
//   fifo_ren, fifo_rdata           : FIFO read strobe, data one cycle later
//   rec_valid, rec_ready           : record handshake
//   rec_data, rec_channel          : assembled record and its channel
//   seq_error, underflow           : one-cycle event pulses
//   clear_counters                 : zero record_count and error_count
//   record_count, error_count      : saturating event counters
module csa_bulk_unpacker
  import csa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = CSA_DATA_WIDTH,
  parameter int unsigned RECORD_WORDS = CSA_OUT_RECORD_WORDS,
  parameter int unsigned CHANNEL_NUM  = 4,
  parameter int unsigned CHANNEL_BITS = csa_chan_bits(CHANNEL_NUM),
  parameter int unsigned SEQ_CHECK    = 1
) (
  input  logic                               axi_mm_clk,
  input  logic                               rst,
  input  logic                               fifo_r_ready,
  input  logic                               fifo_error_empty,
  output logic                               fifo_ren,
  input  logic [DATA_WIDTH-1:0]              fifo_rdata,
  output logic                               rec_valid,
  input  logic                               rec_ready,
  output logic [DATA_WIDTH*RECORD_WORDS-1:0] rec_data,
  output logic [CHANNEL_BITS-1:0]            rec_channel,
  output logic                               seq_error,
  output logic                               underflow,
  input  logic                               clear_counters,
  output logic [31:0]                        record_count,
  output logic [31:0]                        error_count
);

  localparam int unsigned SEQ_BITS = csa_seq_bits(DATA_WIDTH, CHANNEL_BITS);
  localparam int unsigned CNT_W    = $clog2(RECORD_WORDS + 1);
  localparam int unsigned WORD0_LO = DATA_WIDTH * CSA_WORD0_IDX;

  // Elaboration-time parameter guards.
  if (RECORD_WORDS < 2) begin : g_bad_record_words
    $error("csa_bulk_unpacker: RECORD_WORDS must be >= 2");
  end
  if ((CHANNEL_NUM == 0) || ((CHANNEL_NUM & (CHANNEL_NUM - 1)) != 0)) begin : g_bad_channel_num
    $error("csa_bulk_unpacker: CHANNEL_NUM must be a power of two");
  end
  if (CHANNEL_BITS >= DATA_WIDTH) begin : g_bad_channel_bits
    $error("csa_bulk_unpacker: CHANNEL_BITS must leave room for seq");
  end

  csa_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ren_d;
  logic             valid_d;
  logic             underflow_d;
  logic             capture_c;
  logic             check_c;
  logic             handshake_c;
  logic             mismatch_c;
  logic [CNT_W-1:0] widx_c;

  // State register and word counter.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next values of the registered control outputs.
  // In READ the counter runs 0..N: fifo_ren covers counts 0..N-1 and
  // captures trail by one cycle, so counts 1..N land words 0..N-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ren_d       = 1'b0;
    valid_d     = 1'b0;
    underflow_d = 1'b0;
    capture_c   = 1'b0;
    check_c     = 1'b0;
    handshake_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_r_ready) begin
          state_d = READ;
          cnt_d   = '0;
          ren_d   = 1'b1;
        end
      end
      READ: begin
        if (fifo_error_empty) begin
          state_d     = IDLE;
          underflow_d = 1'b1;
        end else begin
          capture_c = (cnt_q != '0);
          if (cnt_q == CNT_W'(RECORD_WORDS)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            check_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            ren_d = (cnt_q < CNT_W'(RECORD_WORDS - 1));
          end
        end
      end
      HOLD: begin
        valid_d = 1'b1;
        if (rec_ready) begin
          handshake_c = 1'b1;
          valid_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign widx_c = cnt_q - CNT_W'(1);

  // Record assembly; partial contents are never exposed with rec_valid.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      rec_data    <= '0;
      rec_channel <= '0;
    end else if (capture_c) begin
      for (int w = 0; w < int'(RECORD_WORDS); w++) begin
        if (widx_c == CNT_W'(w)) begin
          rec_data[w*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
        end
      end
      if (widx_c == CNT_W'(CSA_WORD0_IDX)) begin
        rec_channel <= fifo_rdata[DATA_WIDTH-1 -: CHANNEL_BITS];
      end
    end
  end

  csa_seq_tracker #(
    .CHANNEL_BITS (CHANNEL_BITS),
    .SEQ_BITS     (SEQ_BITS)
  ) u_seq_tracker (
    .axi_mm_clk (axi_mm_clk),
    .rst        (rst),
    .check      (check_c && (SEQ_CHECK != 0)),
    .channel    (rec_channel),
    .seq        (rec_data[WORD0_LO + CSA_SEQ_LSB +: SEQ_BITS]),
    .mismatch_c (mismatch_c)
  );

  // Registered control outputs and saturating counters; clear has priority.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      fifo_ren     <= 1'b0;
      rec_valid    <= 1'b0;
      underflow    <= 1'b0;
      seq_error    <= 1'b0;
      record_count <= '0;
      error_count  <= '0;
    end else begin
      fifo_ren  <= ren_d;
      rec_valid <= valid_d;
      underflow <= underflow_d;
      seq_error <= mismatch_c;
      if (clear_counters) begin
        record_count <= '0;
        error_count  <= '0;
      end else begin
        if (handshake_c && (record_count != 32'hFFFF_FFFF)) begin
          record_count <= record_count + 32'd1;
        end
        if (mismatch_c && (error_count != 32'hFFFF_FFFF)) begin
          error_count <= error_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_bulk_unpacker.sv
// Directed bench for csa_bulk_unpacker with default parameters
// (32-bit words, 7-word records, 4 channels, sequence checking on).
module tb_csa_bulk_unpacker;

  localparam int DW = 32;
  localparam int RW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fifo_r_ready;
  logic            fifo_error_empty = 1'b0;
  logic            fifo_ren;
  logic [DW-1:0]   fifo_rdata = '0;
  logic            rec_valid;
  logic            rec_ready = 1'b0;
  logic [DW*RW-1:0] rec_data;
  logic [1:0]      rec_channel;
  logic            seq_error;
  logic            underflow;
  logic            clear_counters = 1'b0;
  logic [31:0]     record_count;
  logic [31:0]     error_count;

  int checks = 0;
  int errors = 0;

  // Monitor counters
  int cyc = 0;
  int ren_cnt = 0;
  int serr_cnt = 0;
  int uf_cnt = 0;
  int valid_cnt = 0;
  int chan_bad = 0;
  logic [31:0] last_err_w0 = '0;
  logic [31:0] got_w0[$];

  // FIFO model
  logic [DW-1:0] fq[$];

  always #5 clk = ~clk;

  assign fifo_r_ready = (fq.size() >= RW);

  always @(posedge clk) begin
    if (fifo_ren && fq.size() > 0) fifo_rdata <= fq.pop_front();
  end

  always @(negedge clk) begin
    cyc++;
    if (fifo_ren) ren_cnt++;
    if (seq_error) begin
      serr_cnt++;
      last_err_w0 = rec_data[31:0];
    end
    if (underflow) uf_cnt++;
    if (rec_valid) valid_cnt++;
    if (rec_valid && rec_ready) begin
      got_w0.push_back(rec_data[31:0]);
      if (rec_channel !== rec_data[31:30]) chan_bad++;
    end
  end

  csa_bulk_unpacker dut (
    .axi_mm_clk       (clk),
    .rst              (rst),
    .fifo_r_ready     (fifo_r_ready),
    .fifo_error_empty (fifo_error_empty),
    .fifo_ren         (fifo_ren),
    .fifo_rdata       (fifo_rdata),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .rec_data         (rec_data),
    .rec_channel      (rec_channel),
    .seq_error        (seq_error),
    .underflow        (underflow),
    .clear_counters   (clear_counters),
    .record_count     (record_count),
    .error_count      (error_count)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*RW-1:0] mk_rec(input logic [31:0] w0, input logic [31:0] fill);
    logic [DW*RW-1:0] r;
    r[31:0] = w0;
    for (int i = 1; i < RW; i++) r[32*i +: 32] = 32'(fill * 32'(i));
    return r;
  endfunction

  task automatic push_rec(input logic [31:0] w0, input logic [31:0] fill);
    fq.push_back(w0);
    for (int i = 1; i < RW; i++) fq.push_back(32'(fill * 32'(i)));
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!rec_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 256'(rec_valid), 256'(1));
  endtask

  task automatic wait_ren(input string tag, input int max_cyc);
    int n = 0;
    while (!fifo_ren && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 256'(fifo_ren), 256'(1));
  endtask

  task automatic wait_count(input string tag, input logic [31:0] target, input int max_cyc);
    int n = 0;
    while (record_count != target && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 256'(record_count), 256'(target));
  endtask

  logic [DW*RW-1:0] snap;
  logic             stable;
  int               c0, ren0, serr0, uf0, val0;
  logic [31:0]      rc0, ec0;
  logic [31:0]      exp_w0[$];

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_ctrl", 256'({fifo_ren, rec_valid, seq_error, underflow, rec_channel, record_count, error_count}), 256'(0));
    chk("reset_data", 256'(rec_data), 256'(0));
    rst = 1'b0;
    tick();

    // Basic record: ch0 seq1
    rec_ready = 1'b1;
    ren0 = ren_cnt;
    serr0 = serr_cnt;
    push_rec(32'h0000_0001, 32'h11);
    wait_ren("basic_ren_start", 20);
    c0 = cyc;
    wait_valid("basic_valid", 30);
    chk("basic_latency", 256'(cyc - c0), 256'(8));
    chk("basic_data", 256'(rec_data), 256'(mk_rec(32'h0000_0001, 32'h11)));
    chk("basic_channel", 256'(rec_channel), 256'(0));
    tick();
    chk("basic_count", 256'(record_count), 256'(1));
    chk("basic_ren_cycles", 256'(ren_cnt - ren0), 256'(7));
    chk("basic_no_seqerr", 256'(serr_cnt - serr0), 256'(0));

    // Back-pressure: two ch1 records, consumer stalled 20 cycles
    rec_ready = 1'b0;
    push_rec(32'h4000_0001, 32'h101);
    push_rec(32'h4000_0002, 32'h202);
    wait_valid("bp_valid1", 40);
    snap = rec_data;
    chk("bp_data1", 256'(snap), 256'(mk_rec(32'h4000_0001, 32'h101)));
    ren0 = ren_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rec_data !== snap || rec_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", 256'(stable), 256'(1));
    chk("bp_no_ren_in_hold", 256'(ren_cnt - ren0), 256'(0));
    rec_ready = 1'b1;
    tick();
    wait_valid("bp_valid2", 40);
    chk("bp_data2", 256'(rec_data), 256'(mk_rec(32'h4000_0002, 32'h202)));
    tick();
    chk("bp_count", 256'(record_count), 256'(3));

    // Sequence gap on channel 2: 1, 2, 4, 5
    serr0 = serr_cnt;
    push_rec(32'h8000_0001, 32'h3);
    push_rec(32'h8000_0002, 32'h5);
    push_rec(32'h8000_0004, 32'h7);
    push_rec(32'h8000_0005, 32'h9);
    wait_count("gap_count", 32'd7, 200);
    chk("gap_seqerr_pulses", 256'(serr_cnt - serr0), 256'(1));
    chk("gap_err_word0", 256'(last_err_w0), 256'(32'h8000_0004));
    chk("gap_error_count", 256'(error_count), 256'(1));

    // Reset in the middle of READ
    push_rec(32'h0000_0002, 32'h55);
    wait_ren("midrst_ren", 20);
    tick(); tick();
    rst = 1'b1;
    tick();
    fq.delete();
    chk("midrst_ctrl", 256'({fifo_ren, rec_valid, seq_error, underflow, rec_channel, record_count, error_count}), 256'(0));
    chk("midrst_data", 256'(rec_data), 256'(0));
    rst = 1'b0;
    tick();

    // Interleaved channels 0..3, seq 1..3 each; all expected_seq back at 1
    got_w0.delete();
    chan_bad = 0;
    serr0 = serr_cnt;
    for (int s = 1; s <= 3; s++) begin
      for (int ch = 0; ch < 4; ch++) begin
        logic [31:0] w0;
        w0 = {2'(ch), 30'(s)};
        exp_w0.push_back(w0);
        push_rec(w0, 32'(16 * s + ch));
      end
    end
    wait_count("ilv_count", 32'd12, 400);
    chk("ilv_error_count", 256'(error_count), 256'(0));
    chk("ilv_seqerr_pulses", 256'(serr_cnt - serr0), 256'(0));
    chk("ilv_channel_field", 256'(chan_bad), 256'(0));
    chk("ilv_rec_total", 256'(got_w0.size()), 256'(12));
    for (int k = 0; k < 12 && k < got_w0.size(); k++) begin
      chk($sformatf("ilv_order_%0d", k), 256'(got_w0[k]), 256'(exp_w0[k]));
    end

    // Underflow in the 4th read cycle
    rc0 = record_count;
    ec0 = error_count;
    uf0 = uf_cnt;
    push_rec(32'hC000_0004, 32'h77);
    wait_ren("uf_ren", 20);
    tick(); tick(); tick();
    fifo_error_empty = 1'b1;
    tick();
    fifo_error_empty = 1'b0;
    chk("uf_pulse", 256'(underflow), 256'(1));
    chk("uf_ren_dropped", 256'(fifo_ren), 256'(0));
    val0 = valid_cnt;
    for (int i = 0; i < 10; i++) tick();
    fq.delete();
    chk("uf_no_valid", 256'(valid_cnt - val0), 256'(0));
    chk("uf_single_pulse", 256'(uf_cnt - uf0), 256'(1));
    chk("uf_rec_count", 256'(record_count), 256'(rc0));
    chk("uf_err_count", 256'(error_count), 256'(ec0));
    push_rec(32'hC000_0004, 32'h88);
    wait_valid("uf_after_valid", 40);
    chk("uf_after_data", 256'(rec_data), 256'(mk_rec(32'hC000_0004, 32'h88)));
    chk("uf_after_channel", 256'(rec_channel), 256'(3));
    tick();
    chk("uf_after_count", 256'(record_count), 256'(rc0 + 32'd1));
    chk("uf_after_err", 256'(error_count), 256'(0));

    // clear_counters together with a handshake: clear wins
    rec_ready = 1'b0;
    push_rec(32'h0000_0004, 32'h99);
    wait_valid("clr_valid", 40);
    rec_ready = 1'b1;
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    chk("clr_record_count", 256'(record_count), 256'(0));
    chk("clr_error_count", 256'(error_count), 256'(0));
    chk("clr_valid_dropped", 256'(rec_valid), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
